// File: rtl/f1_start_lights.sv
// f1_start_lights: Formula-1 style start-light sequencer fed by a 7-bit LFSR.
// Lamps light one per tick, hold for a random number of ticks, then go out with a go pulse.
module f1_start_lights #(
  parameter int TICK_DIV  = 48,
  parameter int MIN_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic [6:0] rnd,
  output logic       lfsr_en,
  output logic [7:0] lights,
  output logic       busy,
  output logic       go
);
  typedef enum logic [1:0] {IDLE, SEQ, DELAY} state_t;

  localparam logic [15:0] PCNT_MAX = 16'(TICK_DIV - 1);
  localparam logic [7:0]  MIN_DLY  = 8'(MIN_DELAY);

  state_t      state;
  logic [15:0] pcnt;
  logic [7:0]  dly;
  logic [7:0]  dly_sum;
  logic [7:0]  dly_init;
  logic        tick;

  assign tick    = (pcnt == PCNT_MAX) && (state != IDLE);
  // The generator only runs while idle, so the captured value depends on trigger timing.
  assign lfsr_en = (state == IDLE);

  // 7-bit value plus at most 128 fits in 8 bits; a zero sum still waits one tick.
  assign dly_sum  = {1'b0, rnd} + MIN_DLY;
  assign dly_init = (dly_sum == 8'd0) ? 8'd1 : dly_sum;

  // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pcnt   <= '0;
      dly    <= '0;
      lights <= '0;
      busy   <= 1'b0;
      go     <= 1'b0;
    end else begin
      go <= 1'b0;
      unique case (state)
        IDLE: begin
          pcnt   <= '0;
          lights <= '0;
          if (trigger) begin
            state <= SEQ;
            busy  <= 1'b1;
            dly   <= dly_init;
          end
        end
        SEQ: begin
          pcnt <= tick ? '0 : pcnt + 16'd1;
          if (tick) begin
            lights <= {lights[6:0], 1'b1};
            if (lights == 8'h7F) state <= DELAY;
          end
        end
        DELAY: begin
          pcnt <= tick ? '0 : pcnt + 16'd1;
          if (tick) begin
            if (dly == 8'd1) begin
              lights <= '0;
              busy   <= 1'b0;
              go     <= 1'b1;
              state  <= IDLE;
            end else begin
              dly <= dly - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_f1_start_lights.sv
// Scoreboard bench for f1_start_lights: two instances (MIN_DELAY 1 and 0) share stimulus,
// a run-level reference model predicts every cycle's outputs and every go pulse.
module tb_f1_start_lights;
  localparam int TD = 4;

  typedef struct {
    int          cyc;
    logic [10:0] o0;
    logic [10:0] o1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       trigger;
  logic [6:0] rnd;
  logic [7:0] lights [2];
  logic       busy   [2];
  logic       go     [2];
  logic       lfsr_en[2];

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   go_q0[$];
  int   go_q1[$];

  // Reference model: a run is described only by its trigger cycle and delay length.
  bit running[2];
  int t0[2];
  int dd[2];

  f1_start_lights #(.TICK_DIV(TD), .MIN_DELAY(1)) u_dut1 (
    .clk(clk), .rst(rst), .trigger(trigger), .rnd(rnd),
    .lfsr_en(lfsr_en[0]), .lights(lights[0]), .busy(busy[0]), .go(go[0])
  );

  f1_start_lights #(.TICK_DIV(TD), .MIN_DELAY(0)) u_dut0 (
    .clk(clk), .rst(rst), .trigger(trigger), .rnd(rnd),
    .lfsr_en(lfsr_en[1]), .lights(lights[1]), .busy(busy[1]), .go(go[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int min_of(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic bit model_idle(int i, int c);
    return !running[i] || (c - t0[i] - 1 >= (8 + dd[i]) * TD);
  endfunction

  // Expected {lights, busy, go, lfsr_en} in cycle c.
  function automatic logic [10:0] exp_out(int i, int c);
    int e;
    int lamps;
    if (!running[i]) return {8'h00, 3'b001};
    e = c - t0[i] - 1;
    if (e < (8 + dd[i]) * TD) begin
      lamps = (e / TD > 8) ? 8 : e / TD;
      return {8'((1 << lamps) - 1), 3'b100};
    end
    if (e == (8 + dd[i]) * TD) return {8'h00, 3'b011};
    return {8'h00, 3'b001};
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s[inst%0d] cycle %0d: got %0h expected %0h", name, idx, cyc, act, expv);
    end
  endtask

  // Drive inputs for the current cycle, advance the model, queue next-cycle expectations.
  task automatic step(input logic trg, input logic [6:0] r, input logic rs);
    exp_t e;
    int   c = cyc;
    trigger = trg;
    rnd     = r;
    rst     = rs;
    for (int i = 0; i < 2; i++) begin
      if (rs) begin
        running[i] = 1'b0;
        if (i == 0) go_q0.delete(); else go_q1.delete();
      end else if (trg && model_idle(i, c)) begin
        running[i] = 1'b1;
        t0[i]      = c;
        dd[i]      = int'(r) + min_of(i);
        if (dd[i] == 0) dd[i] = 1;
        if (i == 0) go_q0.push_back(c + 1 + (8 + dd[i]) * TD);
        else        go_q1.push_back(c + 1 + (8 + dd[i]) * TD);
      end
    end
    e.cyc = c + 1;
    e.o0  = exp_out(0, c + 1);
    e.o1  = exp_out(1, c + 1);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  function automatic logic [6:0] rand_rnd();
    return ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
  endfunction

  task automatic wait_idle();
    while (!(model_idle(0, cyc) && model_idle(1, cyc))) step(1'b0, rand_rnd(), 1'b0);
  endtask

  // Monitor: compares every cycle's outputs and the timing of each go pulse.
  initial begin
    exp_t e;
    int   want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", 0, {lights[0], busy[0], go[0], lfsr_en[0]}, e.o0);
        check("outputs", 1, {lights[1], busy[1], go[1], lfsr_en[1]}, e.o1);
      end
      if (go[0] === 1'b1) begin
        want = (go_q0.size() > 0) ? go_q0.pop_front() : -1;
        check("go_cycle", 0, cyc, want);
      end
      if (go[1] === 1'b1) begin
        want = (go_q1.size() > 0) ? go_q1.pop_front() : -1;
        check("go_cycle", 1, cyc, want);
      end
    end
  end

  initial begin
    // Reset held two cycles with trigger high.
    step(1'b1, 7'd5, 1'b1);
    step(1'b1, 7'd9, 1'b1);
    step(1'b0, 7'd0, 1'b0);

    // Nominal: rnd=5 at T.
    wait_idle();
    step(1'b1, 7'd5, 1'b0);
    repeat (60) step(1'b0, rand_rnd(), 1'b0);

    // Ignored inputs: trigger pulses mid-run, rnd changes after capture.
    wait_idle();
    step(1'b1, 7'd5, 1'b0);
    for (int i = 1; i <= 60; i++)
      step(i == 10 || i == 40, (i >= 20) ? 7'd127 : rand_rnd(), 1'b0);

    // Maximum delay.
    wait_idle();
    step(1'b1, 7'd127, 1'b0);
    repeat (550) step(1'b0, rand_rnd(), 1'b0);

    // Abort in DELAY, then re-trigger.
    wait_idle();
    step(1'b1, 7'd5, 1'b0);
    for (int i = 1; i <= 115; i++)
      step(i == 50, (i == 50) ? 7'd5 : rand_rnd(), i == 40);

    // Zero delay with trigger held: back-to-back runs accepted in the go cycle.
    wait_idle();
    step(1'b1, 7'd0, 1'b0);
    repeat (120) step(1'b1, 7'd0, 1'b0);

    // Random traffic with occasional resets.
    wait_idle();
    repeat (5000)
      step($urandom_range(0, 9) == 0, rand_rnd(), $urandom_range(0, 799) == 0);

    wait_idle();
    repeat (4) step(1'b0, 7'd0, 1'b0);
    @(posedge clk);
    #2;
    check("go_pending", 0, go_q0.size(), 0);
    check("go_pending", 1, go_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
